fetch_queue: RTL

Instruction fetch stage directly downstream of the `pc_ctr` program counter. Each cycle it issues the current PC to a synchronous instruction memory and captures the returned word with its PC into a small FIFO for decode. It drives `pc_ctr`'s override port in two cases: to hold the PC when the FIFO has no free slot, and to redirect the PC on a flush.

---
 rtl/fetch_queue_if.sv | 43 ++++
 rtl/fetch_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: the PC control loop back to pc_ctr, the instruction
// memory read port, the flush/redirect request and the decode-side queue head.
// The master side is the fetch queue; the slave side is its environment.
interface fetch_queue_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // pc_ctr loop
  logic [PC_WIDTH-1:0]    pc;
  logic                   pc_override;
  logic [PC_WIDTH-1:0]    pc_next;

  // instruction memory read port
  logic                   imem_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  // redirect
  logic                   flush;
  logic [PC_WIDTH-1:0]    flush_pc;

  // decode side
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [CW-1:0]          count;

  modport master (
    input  pc, imem_rdata, flush, flush_pc, out_ready,
    output pc_override, pc_next, imem_en, imem_addr,
           out_valid, out_pc, out_instr, count
  );

  modport slave (
    output pc, imem_rdata, flush, flush_pc, out_ready,
    input  pc_override, pc_next, imem_en, imem_addr,
           out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue. Issues the current PC to a synchronous instruction
// memory, captures {pc, instr} one cycle later into a small FIFO, and steers
// pc_ctr: hold when no slot can be guaranteed, redirect on flush.
module fetch_queue #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic            clk,
  input  logic            rst,
  fetch_queue_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // queue bookkeeping
  logic [AW-1:0]          wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]          rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]          count_reg, count_next;

  // the single outstanding memory request
  logic                   req_valid_reg, req_valid_next;
  logic [PC_WIDTH-1:0]    req_pc_reg, req_pc_next;

  // entry storage (not reset; validity is tracked by the pointers/count)
  logic [PC_WIDTH-1:0]    mem_pc_reg    [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr_reg [DEPTH];

  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   head_valid;
  logic [CW:0]            occupancy;

  // Occupied slots plus the slot the in-flight response will need. A pop in
  // the same cycle is deliberately not credited, which keeps the issue path
  // free of any dependency on out_ready.
  assign occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, req_valid_reg};
  assign issue      = !rst && !bus.flush && (occupancy < (CW + 1)'(DEPTH));
  assign head_valid = (count_reg != '0);
  // The response returning this cycle belongs to the old stream on a flush.
  assign push       = !rst && !bus.flush && req_valid_reg;
  assign pop        = !rst && head_valid && bus.out_ready;

  // Memory port and decode-side outputs.
  always_comb begin
    bus.imem_en   = issue;
    bus.imem_addr = bus.pc;
    bus.out_valid = head_valid;
    bus.out_pc    = mem_pc_reg[rd_ptr_reg];
    bus.out_instr = mem_instr_reg[rd_ptr_reg];
    bus.count     = count_reg;
  end

  // pc_ctr steering: redirect on flush, hold when not issuing, else let it
  // self-increment. During reset pc_ctr resets itself, so no override.
  always_comb begin
    bus.pc_override = 1'b0;
    bus.pc_next     = bus.pc;
    if (rst) begin
      bus.pc_override = 1'b0;
    end else if (bus.flush) begin
      bus.pc_override = 1'b1;
      bus.pc_next     = bus.flush_pc;
    end else if (!issue) begin
      bus.pc_override = 1'b1;
    end
  end

  // Next-state for pointers, count and the request register.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    req_valid_next = req_valid_reg;
    req_pc_next    = req_pc_reg;
    if (rst || bus.flush) begin
      // reset wins over everything; a flush discards queue and in-flight work
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      req_valid_next = 1'b0;
    end else begin
      req_valid_next = issue;
      if (issue) begin
        req_pc_next = bus.pc;
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers with synchronous reset on the control state only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      req_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      req_valid_reg <= req_valid_next;
    end
    req_pc_reg <= req_pc_next;
  end

  // Per-entry write: the tail slot captures the returning word with its PC.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == AW'(gi))) begin
        mem_pc_reg[gi]    <= req_pc_reg;
        mem_instr_reg[gi] <= bus.imem_rdata;
      end
    end
  end

endmodule
